// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants for the sequential restoring divider
package div_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int WA_DEF = 8;
   localparam int WB_DEF = 4;

   // Step counter must reach WA, so it needs clog2(WA+1) bits
   localparam int CW = $clog2(WA_DEF + 1);

   function automatic int cw_of(input int wa);
      return $clog2(wa + 1);
   endfunction

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - start/busy/done request and result bundle of the divider
interface div_if
   import div_pkg::*;
#(
   parameter int WA = WA_DEF,
   parameter int WB = WB_DEF
);
   logic          start;
   logic [WA-1:0] a;
   logic [WB-1:0] b;
   logic          busy;
   logic          done;
   logic [WA-1:0] q;
   logic [WB-1:0] r;
   logic          dbz;

   modport master (output start, a, b, input busy, done, q, r, dbz);
   modport slave  (input start, a, b, output busy, done, q, r, dbz);
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step
   import div_pkg::*;
#(
   parameter int WB = WB_DEF
) (
   input  logic [WB:0]   rem_in,
   input  logic          bit_in,
   input  logic [WB-1:0] divisor,
   output logic [WB:0]   rem_out,
   output logic          qbit
);

   // rem_in is always below the divisor, so its msb is zero; keeping it in the
   // trial value makes the compare exact without relying on that invariant
   logic [WB+1:0] t;
   logic [WB:0]   diff;

   // Shift in the next dividend bit, subtract when it fits, else restore
   always_comb begin
      t       = {rem_in, bit_in};
      diff    = t[WB:0] - {1'b0, divisor};
      qbit    = (t >= {2'b00, divisor});
      rem_out = qbit ? diff : t[WB:0];
   end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring divider, one quotient bit per clock
module div_seq
   import div_pkg::*;
#(
   parameter int WA = WA_DEF,
   parameter int WB = WB_DEF
) (
   input logic   clk,
   input logic   rst,
   div_if.slave  bus
);

   localparam int CNT_W = cw_of(WA);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WA - 1);

   logic [1:0]       state;
   // The dividend register doubles as the working quotient: each step the
   // consumed msb leaves and the new quotient bit enters at the lsb
   logic [WA-1:0]    dvd;
   logic [WB-1:0]    dsr;
   logic [WB:0]      rem;
   logic [CNT_W-1:0] cnt;
   logic [WA-1:0]    q_r;
   logic [WB-1:0]    r_r;
   logic             dbz_r;

   logic [WB:0]      rem_nx;
   logic             qbit;

   div_step #(.WB(WB)) u_step (
      .rem_in  (rem),
      .bit_in  (dvd[WA-1]),
      .divisor (dsr),
      .rem_out (rem_nx),
      .qbit    (qbit)
   );

   // Control FSM, working registers and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         dvd   <= '0;
         dsr   <= '0;
         rem   <= '0;
         cnt   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         dbz_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.b != '0) begin
                     state <= ST_RUN;
                     dvd   <= bus.a;
                     dsr   <= bus.b;
                     rem   <= '0;
                     cnt   <= '0;
                  end else begin
                     // Divide by zero finishes immediately with a fixed result
                     state <= ST_DONE;
                     q_r   <= '1;
                     r_r   <= bus.a[WB-1:0];
                     dbz_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               dvd <= {dvd[WA-2:0], qbit};
               rem <= rem_nx;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state <= ST_DONE;
                  q_r   <= {dvd[WA-2:0], qbit};
                  r_r   <= rem_nx[WB-1:0];
                  dbz_r <= 1'b0;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
   assign bus.q    = q_r;
   assign bus.r    = r_r;
   assign bus.dbz  = dbz_r;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;

   localparam int WA = 8;
   localparam int WB = 4;
   localparam int N_SWEEP = 256 * 15;

   typedef struct {
      logic [WA-1:0] a;
      logic [WB-1:0] b;
      logic [WA-1:0] q;
      logic [WB-1:0] r;
      logic          dbz;
      int            lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   div_if #(.WA(WA), .WB(WB)) bus ();

   div_seq #(.WA(WA), .WB(WB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   // Reference: plain integer division, fixed result for a zero divisor
   function automatic void model(input logic [WA-1:0] ma, input logic [WB-1:0] mb,
                                 output logic [WA-1:0] mq, output logic [WB-1:0] mr,
                                 output logic md);
      if (mb == 0) begin
         mq = '1;
         mr = ma[WB-1:0];
         md = 1'b1;
      end else begin
         mq = ma / mb;
         mr = ma % mb;
         md = 1'b0;
      end
   endfunction

   // One full operation from IDLE: accept, wait for done, check results and return to IDLE
   task automatic do_op(input logic [WA-1:0] ta, input logic [WB-1:0] tb_,
                        input logic [WA-1:0] eq, input logic [WB-1:0] er,
                        input logic ed, input int elat, input string tag);
      int n;
      logic [WA-1:0] q_before;
      logic stable;
      q_before = bus.q;
      stable   = 1'b1;
      bus.start = 1'b1;
      bus.a = ta;
      bus.b = tb_;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = ~ta;
      bus.b = ~tb_;
      chk({tag, "_busy"}, bus.busy, 1);
      n = 0;
      while (!bus.done && n < 20) begin
         if (bus.q !== q_before) stable = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, elat);
      chk({tag, "_qhold"}, stable, 1);
      chk({tag, "_q"}, bus.q, eq);
      chk({tag, "_r"}, bus.r, er);
      chk({tag, "_dbz"}, bus.dbz, ed);
      @(posedge clk); #1;
      chk({tag, "_donedrop"}, bus.done, 0);
      chk({tag, "_idle"}, bus.busy, 0);
   endtask

   vec_t tbl[6];
   logic [WA-1:0] mq;
   logic [WB-1:0] mr;
   logic          md;
   logic [WA-1:0] gq;
   logic [WB-1:0] gr;
   int            got_done;

   initial begin
      tbl[0] = '{a: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4, dbz: 1'b0, lat: WA};
      tbl[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dbz: 1'b0, lat: WA};
      tbl[2] = '{a: 8'd5,   b: 4'd15, q: 8'd0,   r: 4'd5, dbz: 1'b0, lat: WA};
      tbl[3] = '{a: 8'd0,   b: 4'd9,  q: 8'd0,   r: 4'd0, dbz: 1'b0, lat: WA};
      tbl[4] = '{a: 8'hA7,  b: 4'd0,  q: 8'hFF,  r: 4'h7, dbz: 1'b1, lat: 0};
      tbl[5] = '{a: 8'd12,  b: 4'd4,  q: 8'd3,   r: 4'd0, dbz: 1'b0, lat: WA};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_q", bus.q, 0);
      chk("rst_r", bus.r, 0);
      chk("rst_dbz", bus.dbz, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat,
               $sformatf("tbl%0d", i));

      // Starts during RUN and DONE must be ignored
      bus.start = 1'b1;
      bus.a = 8'd100;
      bus.b = 4'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a = 8'd9;
      bus.b = 4'd2;
      got_done = 0;
      gq = '0;
      gr = '0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            got_done++;
            gq = bus.q;
            gr = bus.r;
         end
         bus.start = (k == 3 || k == 8);
      end
      bus.start = 1'b0;
      chk("ign_done_cnt", got_done, 1);
      chk("ign_q", gq, 33);
      chk("ign_r", gr, 1);
      chk("ign_idle", bus.busy, 0);

      // Asynchronous reset mid-operation
      bus.start = 1'b1;
      bus.a = 8'd200;
      bus.b = 4'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_q", bus.q, 0);
      chk("arst_r", bus.r, 0);
      chk("arst_dbz", bus.dbz, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(8'd50, 4'd6, 8'd8, 4'd2, 1'b0, WA, "post_rst");

      // Randomized operations, zero divisor included
      for (int i = 0; i < 30; i++) begin
         logic [WA-1:0] ra;
         logic [WB-1:0] rb;
         ra = WA'($urandom_range(0, 255));
         rb = WB'($urandom_range(0, 15));
         model(ra, rb, mq, mr, md);
         do_op(ra, rb, mq, mr, md, (rb == 0) ? 0 : WA, $sformatf("rnd%0d", i));
      end

      // Exhaustive back-to-back sweep with start held high
      begin
         logic [WA+WB-1:0] pend[$];
         logic [WA+WB-1:0] ent;
         logic prev_busy;
         int idx, done_cnt, cyc, bad;
         idx = 0;
         done_cnt = 0;
         cyc = 0;
         bad = 0;
         prev_busy = bus.busy;
         bus.a = WA'(idx / 15);
         bus.b = WB'(idx % 15 + 1);
         bus.start = 1'b1;
         while (done_cnt < N_SWEEP && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.busy && !prev_busy) begin
               pend.push_back({bus.a, bus.b});
               idx++;
               if (idx < N_SWEEP) begin
                  bus.a = WA'(idx / 15);
                  bus.b = WB'(idx % 15 + 1);
               end else begin
                  bus.start = 1'b0;
               end
            end
            if (bus.done) begin
               if (pend.size() == 0) begin
                  chk("sweep_spurious_done", 1, 0);
               end else begin
                  ent = pend.pop_front();
                  model(ent[WA+WB-1:WB], ent[WB-1:0], mq, mr, md);
                  n_total++;
                  if (bus.q === mq && bus.r === mr && bus.dbz === md) n_pass++;
                  else if (bad++ < 10)
                     $display("FAIL sweep a=%0d b=%0d: got q=%0d r=%0d dbz=%0d want q=%0d r=%0d dbz=%0d",
                              ent[WA+WB-1:WB], ent[WB-1:0], bus.q, bus.r, bus.dbz, mq, mr, md);
               end
               done_cnt++;
            end
            prev_busy = bus.busy;
         end
         bus.start = 1'b0;
         chk("sweep_count", done_cnt, N_SWEEP);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
